// File: rtl/dds_sequencer.sv
// dds_sequencer: coefficient holder and sample pacer in front of the sine
// oscillator. Host writes land in a shadow bank; an active bank, copied on
// every LOAD, drives the oscillator so a running tone is never disturbed.
//
// Pulse protocol toward the oscillator: DDSReady is a one-cycle seed strobe
// during which init_1/init_2/DDSMode are already valid and stay stable until
// the next DDSReady; DDSEnable is a one-cycle sample tick, only in RUN and
// never in the same cycle as DDSReady. No back-pressure exists.
module dds_sequencer #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic        Fg_CLK,
  input  logic        Fg_RESETn,
  input  logic        CfgWrEn,
  input  logic [1:0]  CfgAddr,
  input  logic [31:0] CfgWrData,
  input  logic        Start,
  input  logic        Stop,
  input  logic [2:0]  ModeIn,
  output logic [31:0] init_1,
  output logic [31:0] init_2,
  output logic [2:0]  DDSMode,
  output logic        DDSReady,
  output logic        DDSEnable,
  output logic        Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state_q, state_nxt;

  // Shadow bank (host side)
  logic [31:0]        sh_sin_q, sh_sin_nxt;
  logic [31:0]        sh_cos_q, sh_cos_nxt;
  logic [DIV_W-1:0]   sh_div_q, sh_div_nxt;
  logic [CNT_W-1:0]   sh_rsn_q, sh_rsn_nxt;

  // Active pacing parameters (coefficients live directly in init_1/init_2)
  logic [DIV_W-1:0]   act_div_q, act_div_nxt;
  logic [CNT_W-1:0]   act_rsn_q, act_rsn_nxt;
  logic [31:0]        init_1_nxt, init_2_nxt;
  logic [2:0]         mode_nxt;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_nxt;
  logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_nxt;

  logic               tick;
  logic [CNT_W-1:0]   samp_inc;
  logic               resync_hit;
  logic               enable_nxt;

  // Next-state, shadow/active bank updates and pre-computed registered outputs
  always_comb begin
    sh_sin_nxt   = sh_sin_q;
    sh_cos_nxt   = sh_cos_q;
    sh_div_nxt   = sh_div_q;
    sh_rsn_nxt   = sh_rsn_q;
    state_nxt    = state_q;
    act_div_nxt  = act_div_q;
    act_rsn_nxt  = act_rsn_q;
    init_1_nxt   = init_1;
    init_2_nxt   = init_2;
    mode_nxt     = DDSMode;
    div_cnt_nxt  = div_cnt_q;
    samp_cnt_nxt = samp_cnt_q;

    // A write on the same edge as Start must reach that LOAD, so the active
    // bank copies from the post-write shadow values.
    if (CfgWrEn) begin
      case (CfgAddr)
        2'd0:    sh_sin_nxt = CfgWrData;
        2'd1:    sh_cos_nxt = CfgWrData;
        2'd2:    sh_div_nxt = CfgWrData[DIV_W-1:0];
        default: sh_rsn_nxt = CfgWrData[CNT_W-1:0];
      endcase
    end

    // The current cycle carries a tick exactly when DDSEnable is high.
    tick       = (state_q == S_RUN) && (div_cnt_q == act_div_q);
    samp_inc   = (samp_cnt_q == {CNT_W{1'b1}}) ? samp_cnt_q
                                               : samp_cnt_q + CNT_W'(1);
    resync_hit = tick && (act_rsn_q != '0) && (samp_inc == act_rsn_q);

    if (Stop) begin
      state_nxt = S_IDLE;
    end else if (Start) begin
      state_nxt = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  state_nxt = S_RUN;
        S_RUN:   state_nxt = resync_hit ? S_LOAD : S_RUN;
        default: state_nxt = state_q;
      endcase
    end

    if (state_nxt == S_LOAD) begin
      init_1_nxt   = sh_sin_nxt;
      init_2_nxt   = sh_cos_nxt;
      act_div_nxt  = sh_div_nxt;
      act_rsn_nxt  = sh_rsn_nxt;
      mode_nxt     = ModeIn;
      div_cnt_nxt  = '0;
      samp_cnt_nxt = '0;
    end else if (state_q == S_RUN) begin
      div_cnt_nxt  = tick ? '0 : div_cnt_q + DIV_W'(1);
      if (tick) samp_cnt_nxt = samp_inc;
    end

    enable_nxt = (state_nxt == S_RUN) && (div_cnt_nxt == act_div_nxt);
  end

  // State, banks, counters and all outputs; async clear on reset
  always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
    if (!Fg_RESETn) begin
      state_q    <= S_IDLE;
      sh_sin_q   <= '0;
      sh_cos_q   <= '0;
      sh_div_q   <= '0;
      sh_rsn_q   <= '0;
      act_div_q  <= '0;
      act_rsn_q  <= '0;
      div_cnt_q  <= '0;
      samp_cnt_q <= '0;
      init_1     <= '0;
      init_2     <= '0;
      DDSMode    <= '0;
      DDSReady   <= 1'b0;
      DDSEnable  <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      sh_sin_q   <= sh_sin_nxt;
      sh_cos_q   <= sh_cos_nxt;
      sh_div_q   <= sh_div_nxt;
      sh_rsn_q   <= sh_rsn_nxt;
      act_div_q  <= act_div_nxt;
      act_rsn_q  <= act_rsn_nxt;
      div_cnt_q  <= div_cnt_nxt;
      samp_cnt_q <= samp_cnt_nxt;
      init_1     <= init_1_nxt;
      init_2     <= init_2_nxt;
      DDSMode    <= mode_nxt;
      DDSReady   <= (state_nxt == S_LOAD);
      DDSEnable  <= enable_nxt;
      Busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_dds_sequencer.sv
// tb_dds_sequencer: directed table, hand-written corner sequences and
// randomized traffic, all checked every cycle against a cycle-count model.
module tb_dds_sequencer;

  logic        Fg_CLK = 1'b0;
  logic        Fg_RESETn;
  logic        CfgWrEn;
  logic [1:0]  CfgAddr;
  logic [31:0] CfgWrData;
  logic        Start;
  logic        Stop;
  logic [2:0]  ModeIn;
  logic [31:0] init_1;
  logic [31:0] init_2;
  logic [2:0]  DDSMode;
  logic        DDSReady;
  logic        DDSEnable;
  logic        Busy;

  int n_cmp = 0;
  int n_bad = 0;

  dds_sequencer #(.DIV_W(16), .CNT_W(32)) dut (
    .Fg_CLK    (Fg_CLK),
    .Fg_RESETn (Fg_RESETn),
    .CfgWrEn   (CfgWrEn),
    .CfgAddr   (CfgAddr),
    .CfgWrData (CfgWrData),
    .Start     (Start),
    .Stop      (Stop),
    .ModeIn    (ModeIn),
    .init_1    (init_1),
    .init_2    (init_2),
    .DDSMode   (DDSMode),
    .DDSReady  (DDSReady),
    .DDSEnable (DDSEnable),
    .Busy      (Busy)
  );

  // ---------------- clock / reset ----------------
  always #5 Fg_CLK = ~Fg_CLK;

  // ---------------- reference model ----------------
  // Phase: 0 idle, 1 seed cycle, 2 running. In running, k counts cycles since
  // the seed cycle (first running cycle is k=1); a tick lands on every
  // multiple of (divider+1), and the tick number is k/(divider+1).
  logic [31:0] m_sh[4];
  int          m_phase;
  longint      m_k;
  logic [31:0] m_i1, m_i2;
  logic [2:0]  m_mode;
  longint      m_div, m_rsn;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_sh[i] = '0;
    m_phase = 0; m_k = 0; m_i1 = '0; m_i2 = '0; m_mode = '0;
    m_div = 0; m_rsn = 0;
  endtask

  task automatic model_seed();
    m_phase = 1;
    m_i1    = m_sh[0];
    m_i2    = m_sh[1];
    m_div   = longint'(m_sh[2][15:0]);
    m_rsn   = longint'(m_sh[3]);
    m_mode  = ModeIn;
  endtask

  task automatic model_edge();
    if (CfgWrEn) m_sh[CfgAddr] = CfgWrData;
    if (Stop) m_phase = 0;
    else if (Start) model_seed();
    else if (m_phase == 1) begin
      m_phase = 2; m_k = 1;
    end else if (m_phase == 2) begin
      if ((m_k % (m_div + 1)) == 0 && m_rsn != 0 && (m_k / (m_div + 1)) == m_rsn)
        model_seed();
      else
        m_k++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("init_1",    init_1, m_i1);
    chk("init_2",    init_2, m_i2);
    chk("DDSMode",   32'(DDSMode), 32'(m_mode));
    chk("DDSReady",  32'(DDSReady), 32'(m_phase == 1));
    chk("DDSEnable", 32'(DDSEnable), 32'(m_phase == 2 && (m_k % (m_div + 1)) == 0));
    chk("Busy",      32'(Busy), 32'(m_phase != 0));
    chk("ready_and_enable", 32'(DDSReady && DDSEnable), 32'd0);
    chk("enable_while_idle", 32'(DDSEnable && !Busy), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change only after a falling edge; outputs are checked on the
  // falling edge after the rising edge the model has just consumed.
  task automatic cycle();
    @(posedge Fg_CLK);
    model_edge();
    @(negedge Fg_CLK);
    check_all();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    CfgWrEn = 1'b1; CfgAddr = a; CfgWrData = d;
    cycle();
    CfgWrEn = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1; cycle(); Start = 1'b0;
  endtask

  task automatic pulse_stop();
    Stop = 1'b1; cycle(); Stop = 1'b0;
  endtask

  typedef struct {
    logic start;
    logic stop;
    logic exp_ready;
    logic exp_en;
    logic exp_busy;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] sin_c, cos_c, cos_new;
  int          ticks;

  initial begin
    Fg_RESETn = 1'b0; CfgWrEn = 1'b0; CfgAddr = '0; CfgWrData = '0;
    Start = 1'b0; Stop = 1'b0; ModeIn = '0;
    model_reset();
    sin_c = 32'($rtoi($floor($sin(3.14159265358979 / 8.0) * 536870912.0 + 0.5)));
    cos_c = 32'($rtoi($floor(2.0 * $cos(3.14159265358979 / 8.0) * 536870912.0 + 0.5)));

    // Expected outputs one cycle after each row's edge; Start at row 0.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4].exp_en = 1'b1;
    tbl[8].exp_en = 1'b1;
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge Fg_CLK);
    check_all();
    Fg_RESETn = 1'b1;
    repeat (2) cycle();

    // Directed table: divider = 3, pi/8 coefficients
    cfg_write(2'd0, sin_c);
    cfg_write(2'd1, cos_c);
    cfg_write(2'd2, 32'd3);
    cfg_write(2'd3, 32'd0);
    ModeIn = 3'd5;
    for (int i = 0; i < 11; i++) begin
      Start = tbl[i].start; Stop = tbl[i].stop;
      cycle();
      Start = 1'b0; Stop = 1'b0;
      chk("tbl_ready",  32'(DDSReady),  32'(tbl[i].exp_ready));
      chk("tbl_enable", 32'(DDSEnable), 32'(tbl[i].exp_en));
      chk("tbl_busy",   32'(Busy),      32'(tbl[i].exp_busy));
      if (tbl[i].exp_ready) begin
        chk("tbl_init_1", init_1, sin_c);
        chk("tbl_init_2", init_2, cos_c);
        chk("tbl_mode", 32'(DDSMode), 32'd5);
      end
    end

    // Resync: divider 0, resync_n 16 -> 16 ticks, one seed cycle, repeat
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd3, 32'd16);
    pulse_start();
    chk("resync_first_ready", 32'(DDSReady), 32'd1);
    for (int r = 0; r < 3; r++) begin
      ticks = 0;
      for (int i = 0; i < 16; i++) begin
        cycle();
        if (DDSEnable) ticks++;
      end
      chk("resync_tick_count", 32'(ticks), 32'd16);
      cycle();
      chk("resync_ready", 32'(DDSReady), 32'd1);
      chk("resync_ready_no_en", 32'(DDSEnable), 32'd0);
    end

    // Shadow write while running stays invisible until the next Start
    cfg_write(2'd2, 32'd2);
    cfg_write(2'd3, 32'd0);
    pulse_start();
    cos_new = cos_c ^ 32'h0F0F_1234;
    cfg_write(2'd1, cos_new);
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("shadow_hold_init_2", init_2, cos_c);
    end
    pulse_start();
    chk("shadow_load_ready", 32'(DDSReady), 32'd1);
    chk("shadow_load_init_2", init_2, cos_new);

    // Start and Stop together from RUN -> IDLE, no seed
    repeat (5) cycle();
    Start = 1'b1; Stop = 1'b1;
    cycle();
    Start = 1'b0; Stop = 1'b0;
    chk("startstop_ready", 32'(DDSReady), 32'd0);
    chk("startstop_busy",  32'(Busy), 32'd0);

    // Reset mid-run: outputs clear at once, then stay quiet without Start
    pulse_start();
    repeat (4) cycle();
    #2 Fg_RESETn = 1'b0;
    #1;
    model_reset();
    chk("rst_init_1", init_1, 32'd0);
    chk("rst_init_2", init_2, 32'd0);
    chk("rst_outputs", {26'd0, DDSMode, DDSReady, DDSEnable, Busy}, 32'd0);
    @(negedge Fg_CLK);
    Fg_RESETn = 1'b1;
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (DDSEnable || DDSReady) ticks++;
    end
    chk("post_reset_quiet", 32'(ticks), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      CfgWrEn = ($urandom_range(0, 3) == 0);
      CfgAddr = 2'($urandom_range(0, 3));
      case (CfgAddr)
        2'd2:    CfgWrData = $urandom_range(0, 4);
        2'd3:    CfgWrData = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom_range(1, 8);
        default: CfgWrData = $urandom;
      endcase
      Start  = ($urandom_range(0, 40) == 0);
      Stop   = ($urandom_range(0, 70) == 0);
      ModeIn = 3'($urandom_range(0, 7));
      cycle();
    end
    CfgWrEn = 1'b0; Start = 1'b0; Stop = 1'b0;
    pulse_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
